// File: rtl/axis_fifo_reader_if.sv
// Signal bundle between a show-ahead FIFO read port, the reader adapter and
// the downstream AXI-Stream sink. The master modport is the adapter's view.
interface axis_fifo_reader_if #(
  parameter int width = 8
);
  logic [width-1:0] fifo_read_data;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [width-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic             pkt_done;

  modport master (
    input  fifo_read_data, fifo_empty, m_tready,
    output fifo_pop, m_tdata, m_tvalid, m_tlast, pkt_done
  );

  modport slave (
    output fifo_read_data, fifo_empty, m_tready,
    input  fifo_pop, m_tdata, m_tvalid, m_tlast, pkt_done
  );
endinterface

// File: rtl/axis_fifo_reader.sv
// Drains a show-ahead FIFO through a 2-entry skid buffer onto an AXI-Stream
// master port, framing beats into fixed-length packets with m_tlast.
module axis_fifo_reader #(
  parameter int width   = 8,
  parameter int pkt_len = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axis_fifo_reader_if.master     bus
);

  localparam int                beat_w    = (pkt_len > 1) ? $clog2(pkt_len) : 1;
  localparam logic [beat_w-1:0] last_beat = beat_w'(pkt_len - 1);

  logic [width-1:0]  buf_r [2];
  logic              head_r;
  logic [1:0]        cnt_r;
  logic [beat_w-1:0] beat_r;
  logic              pkt_done_r;

  logic              pop_s;
  logic              hs_s;
  logic              last_s;
  logic              tail_s;
  logic              head_nx_s;
  logic [1:0]        cnt_nx_s;
  logic [beat_w-1:0] beat_nx_s;
  logic              done_nx_s;

  // Pop/handshake decode and next-state for occupancy, head and packet beat.
  always_comb begin
    pop_s     = rst_n && !bus.fifo_empty && (cnt_r != 2'd2);
    hs_s      = (cnt_r != 2'd0) && bus.m_tready;
    last_s    = (beat_r == last_beat);
    // Tail is the head when empty and the other slot when one entry is held.
    tail_s    = head_r ^ cnt_r[0];
    cnt_nx_s  = cnt_r;
    head_nx_s = head_r;
    beat_nx_s = beat_r;
    done_nx_s = 1'b0;

    if (pop_s && !hs_s) begin
      cnt_nx_s = cnt_r + 2'd1;
    end else if (!pop_s && hs_s) begin
      cnt_nx_s = cnt_r - 2'd1;
    end else begin
      cnt_nx_s = cnt_r;
    end

    if (hs_s) begin
      head_nx_s = ~head_r;
      done_nx_s = last_s;
      if (last_s) begin
        beat_nx_s = {beat_w{1'b0}};
      end else begin
        beat_nx_s = beat_r + beat_w'(1'b1);
      end
    end else begin
      head_nx_s = head_r;
      beat_nx_s = beat_r;
    end
  end

  // Buffer, occupancy, beat counter and packet-done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r[0]   <= {width{1'b0}};
      buf_r[1]   <= {width{1'b0}};
      head_r     <= 1'b0;
      cnt_r      <= 2'd0;
      beat_r     <= {beat_w{1'b0}};
      pkt_done_r <= 1'b0;
    end else begin
      if (pop_s) begin
        buf_r[tail_s] <= bus.fifo_read_data;
      end
      head_r     <= head_nx_s;
      cnt_r      <= cnt_nx_s;
      beat_r     <= beat_nx_s;
      pkt_done_r <= done_nx_s;
    end
  end

  assign bus.fifo_pop = pop_s;
  assign bus.m_tvalid = (cnt_r != 2'd0);
  assign bus.m_tdata  = buf_r[head_r];
  assign bus.m_tlast  = last_s;
  assign bus.pkt_done = pkt_done_r;

endmodule
